// File: rtl/ram_read_checker.sv
// rtl/ram_read_checker.sv - RAM read-stream checker: aligns BRAM read data to the address strobe and verifies the fill pattern
module ram_read_checker #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1,
  parameter int BASE         = 1,
  parameter int STEP         = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              addr_valid,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [DATA_W-1:0] L_BASE   = DATA_W'(BASE);
  localparam logic [DATA_W-1:0] L_STEP   = DATA_W'(STEP);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [READ_LATENCY-1:0] r_vpipe;
  logic [ADDR_W-1:0]       r_idx;
  logic [DATA_W-1:0]       r_expected;
  logic                    r_pass;
  logic [ADDR_W:0]         r_err_cnt;
  logic [ADDR_W-1:0]       r_first_err_idx;
  logic [DATA_W-1:0]       r_first_err_data;
  logic [DATA_W-1:0]       r_checksum;

  logic w_dvalid;
  logic w_cmp;
  logic w_mismatch;
  logic w_last;
  logic w_start_ok;

  assign w_dvalid   = r_vpipe[READ_LATENCY-1];
  assign w_cmp      = (r_state == S_RUN) && w_dvalid;
  assign w_mismatch = w_cmp && (din != r_expected);
  assign w_last     = w_cmp && (r_idx == LAST_IDX);
  assign w_start_ok = (r_state == S_IDLE) && start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Valid pipeline only runs in RUN, so strobes outside a run never reach the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpipe <= '0;
    end else if ((r_state == S_RUN) && !w_last) begin
      r_vpipe[0] <= addr_valid;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
    end else begin
      r_vpipe <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx            <= '0;
      r_expected       <= '0;
      r_pass           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_checksum       <= '0;
    end else if (w_start_ok) begin
      r_idx            <= '0;
      r_expected       <= L_BASE;
      r_pass           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_checksum       <= '0;
    end else if (w_cmp) begin
      r_idx      <= r_idx + IDX_ONE;
      r_expected <= r_expected + L_STEP;
      r_checksum <= r_checksum + din;
      if (w_mismatch) begin
        r_err_cnt <= r_err_cnt + CNT_ONE;
        if (r_err_cnt == '0) begin
          r_first_err_idx  <= r_idx;
          r_first_err_data <= din;
        end
      end
    end else if (r_state == S_DONE) begin
      r_pass <= (r_err_cnt == '0);
    end
  end

  assign busy           = (r_state == S_RUN);
  assign done           = (r_state == S_DONE);
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_err_idx  = r_first_err_idx;
  assign first_err_data = r_first_err_data;
  assign checksum       = r_checksum;

endmodule

// File: doc/ram_read_checker.md
Name: ram_read_checker

Overview:
- Downstream consumer of the dual-port block RAM read stream (port B data output).
- Aligns incoming read data to the read-address strobe across the BRAM read latency.
- Compares each word against the expected fill pattern and accumulates an error count, the first-error location and a running checksum.
- Reports a pass/fail verdict with a done pulse, for use in on-board RAM self-test.

Parameters:
- DATA_W, 16, read data width
- DEPTH, 1024, number of words checked per run
- ADDR_W, 10, index width (log2 DEPTH)
- READ_LATENCY, 1, cycles from addr_valid to valid din; legal range 1..4
- BASE, 1, expected value at index 0
- STEP, 1, expected increment per index

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a check run (tied to the read-side start)
- addr_valid  in  1  high in each cycle a new read address was presented to the RAM
- din  in  DATA_W  RAM read data (doutb)
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the run completes
- pass  out  1  verdict of the last completed run, 1 = no mismatches
- err_cnt  out  ADDR_W+1  mismatch count of the current or last run
- first_err_idx  out  ADDR_W  index of the first mismatch
- first_err_data  out  DATA_W  din value at the first mismatch
- checksum  out  DATA_W  sum of all checked din words, mod 2^DATA_W

Behaviour:
- Interface (decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; valid pipeline 0; idx 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - addr_valid and din are ignored; the valid pipeline is held at 0.
  - On start=1: go to RUN next cycle and clear err_cnt, first_err_idx, first_err_data, checksum, pass and idx. The clear is visible the cycle after start.
- Valid alignment:
  - In RUN, addr_valid feeds a READ_LATENCY-deep shift register.
  - The shift register output is dvalid; din is sampled only when dvalid=1.
  - Gaps in addr_valid are allowed; data order is preserved.
- Compare, in each RUN cycle with dvalid=1:
  - expected = (BASE + idx*STEP) mod 2^DATA_W, computed incrementally (an add per word, no multiplier).
  - checksum <= checksum + din, wrapping.
  - If din != expected: err_cnt increments. If this is the first mismatch (err_cnt was 0), capture first_err_idx=idx and first_err_data=din.
  - idx increments.
- End of run:
  - When the compare at idx=DEPTH-1 occurs, the FSM goes to DONE next cycle. That compare is included in err_cnt.
  - Extra dvalid pulses after that point are ignored.
- DONE (exactly one cycle):
  - done=1; pass <= (err_cnt==0); go to IDLE.
- Output hold: pass, err_cnt, first_err_*, checksum hold their values until the next start.
- Simultaneous events:
  - start while in RUN or DONE is ignored (no restart).
  - start in the same cycle as the DONE->IDLE transition is ignored; the next start in IDLE is accepted.
- Widths:
  - err_cnt holds up to DEPTH (1024) with no saturation needed.
  - idx wraps never within a run.
- Reset mid-run: async clear to reset values immediately; no done pulse.
- busy=1 exactly in RUN.
- Latency: done asserts READ_LATENCY+1 cycles after the last addr_valid in an uninterrupted stream.

Test Plan:
- Clean run: start, 1024 consecutive addr_valid, din = idx+1 delayed 1 cycle -> done pulse, pass=1, err_cnt=0, checksum = 524800 mod 65536 = 0x0200.
- Single fault: same, but din at idx 300 = 0xDEAD -> pass=0, err_cnt=1, first_err_idx=300, first_err_data=0xDEAD.
- Multiple faults plus gappy valid: addr_valid every other cycle, faults at idx 5 and 900 -> err_cnt=2, first_err_idx=5, done 2 cycles after last valid.
- Latency param: READ_LATENCY=3 with din delayed 3 cycles, clean pattern -> pass=1; same stimulus with din delayed only 1 cycle -> pass=0.
- Ignored start: pulse start at word 500 of a clean run -> run completes at word 1023 with pass=1, no restart; results hold until next start.
- Reset mid-run: assert rst at word 700 -> all outputs 0 immediately, no done; a following clean run gives pass=1.
